pixel_stream_buffer: RTL

PIXEL_STREAM_BUFFER -- requirements
Module: pixel_stream_buffer

---
 rtl/hdmi_pkg.sv | 10 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/pixel_stream_buffer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/hdmi_pkg.sv
// Shared HDMI pixel-path definitions: pixel width, FIFO word width and buffer FSM states.
package hdmi_pkg;
  localparam int PIXEL_W = 24;
  localparam int WORD_W  = PIXEL_W + 1;

  typedef enum logic {
    ST_RESYNC = 1'b0,
    ST_RUN    = 1'b1
  } buf_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head-of-queue read port and an occupancy count.
module sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == FULL_LVL);
  assign level = r_count;
endmodule

// File: rtl/pixel_stream_buffer.sv
// Buffers a producer pixel stream and returns frame-aligned pixels to a requesting core,
// dropping data until a start-of-frame lines up with the core's frame start.
module pixel_stream_buffer
  import hdmi_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [PIXEL_W-1:0]     s_data,
  input  logic                   s_sof,
  input  logic                   i_req,
  input  logic                   i_frame_start,
  output logic                   o_rgb_valid,
  output logic [7:0]             o_rgb_red,
  output logic [7:0]             o_rgb_grn,
  output logic [7:0]             o_rgb_blu,
  output logic [$clog2(DEPTH):0] o_level,
  output logic [15:0]            o_err_count,
  output logic                   o_locked
);
  // Handshake: a pixel is pushed on a clk edge where s_valid and s_ready are both 1;
  // s_ready is held low during reset and for the remainder of that cycle after release.
  buf_state_e         r_state;
  buf_state_e         w_state_nxt;
  logic               r_ready_en;
  logic               r_rgb_valid;
  logic [PIXEL_W-1:0] r_rgb;
  logic [15:0]        r_err_count;

  logic               w_push;
  logic               w_pop;
  logic [WORD_W-1:0]  w_head;
  logic               w_head_sof;
  logic               w_empty;
  logic               w_full;
  logic               w_rgb_valid_nxt;
  logic [PIXEL_W-1:0] w_rgb_nxt;
  logic               w_err_inc;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({s_sof, s_data}),
    .rdata (w_head),
    .empty (w_empty),
    .full  (w_full),
    .level (o_level)
  );

  assign s_ready    = r_ready_en & ~w_full;
  assign w_push     = s_valid & s_ready;
  assign w_head_sof = w_head[WORD_W-1];

  always_comb begin
    w_state_nxt     = r_state;
    w_pop           = 1'b0;
    w_rgb_valid_nxt = 1'b0;
    w_rgb_nxt       = r_rgb;
    w_err_inc       = 1'b0;
    // Any request that does not return a pixel zeroes the colour outputs.
    if (i_req) w_rgb_nxt = '0;
    case (r_state)
      ST_RESYNC: begin
        if (!w_empty) begin
          if (!w_head_sof) begin
            w_pop = 1'b1;
          end else if (i_req && i_frame_start) begin
            w_pop           = 1'b1;
            w_rgb_valid_nxt = 1'b1;
            w_rgb_nxt       = w_head[PIXEL_W-1:0];
            w_state_nxt     = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (i_req) begin
          if (!w_empty && (w_head_sof == i_frame_start)) begin
            w_pop           = 1'b1;
            w_rgb_valid_nxt = 1'b1;
            w_rgb_nxt       = w_head[PIXEL_W-1:0];
          end else begin
            w_err_inc   = 1'b1;
            w_state_nxt = ST_RESYNC;
          end
        end
      end
      default: w_state_nxt = ST_RESYNC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RESYNC;
      r_ready_en  <= 1'b0;
      r_rgb_valid <= 1'b0;
      r_rgb       <= '0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready_en  <= 1'b1;
      r_rgb_valid <= w_rgb_valid_nxt;
      r_rgb       <= w_rgb_nxt;
      if (w_err_inc && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
    end
  end

  assign o_rgb_valid = r_rgb_valid;
  assign o_rgb_red   = r_rgb[23:16];
  assign o_rgb_grn   = r_rgb[15:8];
  assign o_rgb_blu   = r_rgb[7:0];
  assign o_err_count = r_err_count;
  assign o_locked    = (r_state == ST_RUN);
endmodule
